// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32 data-memory controller with wait states and stall handshake.
// Define DMEM_MISALIGN_EN to reject unaligned H/W requests with a misaligned pulse.
module dmem_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [31:0]       ddata_w,
    output logic [31:0]       ddata_r,
    output logic              stall,
    output logic              misaligned
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT =
        (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE, S_WAIT, S_ACCESS, S_DONE
    } state_t;

    state_t state, nstate;

    logic          req, accept, aligned;
    logic          is_b, is_h, is_w;
    logic [1:0]    lane_in;
    logic [3:0]    cnt;
    logic [IW-1:0] idx_q;
    logic [1:0]    lane_q;
    logic [2:0]    f3_q;
    logic          wr_q;
    logic [31:0]   wd_q;
    logic [31:0]   word, shifted, load_val, wdat;
    logic [3:0]    be;
    logic [31:0]   mem [DEPTH_WORDS];

    assign req  = MemRead | MemWrite;
    assign is_b = (funct3[1:0] == 2'b00);
    assign is_h = (funct3[1:0] == 2'b01);
    assign is_w = ~is_b & ~is_h;

`ifdef DMEM_MISALIGN_EN
    assign aligned = ~((is_h & daddr[0]) | (is_w & |daddr[1:0]));
`else
    assign aligned = 1'b1;
`endif

    // Low address bits below the access size are dropped when unaligned
    assign lane_in = is_w ? 2'b00 :
                     is_h ? {daddr[1], 1'b0} : daddr[1:0];

    assign accept = (state == S_IDLE) & req & aligned;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= S_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            S_IDLE:
                if (accept)
                    nstate = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (cnt == 4'd0) nstate = S_ACCESS;
            S_ACCESS: nstate = S_DONE;
            S_DONE:   nstate = S_IDLE;
            default:  nstate = S_IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        misaligned = 1'b0;
        unique case (state)
            S_IDLE: begin
                stall      = ~RESET & req & aligned;
                misaligned = ~RESET & req & ~aligned;
            end
            S_WAIT, S_ACCESS: stall = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt     <= 4'd0;
            idx_q   <= '0;
            lane_q  <= 2'b00;
            f3_q    <= 3'b000;
            wr_q    <= 1'b0;
            wd_q    <= 32'd0;
            ddata_r <= 32'd0;
        end else begin
            if (accept) begin
                idx_q  <= daddr[IW+1:2];
                lane_q <= lane_in;
                f3_q   <= funct3;
                wr_q   <= MemWrite;
                wd_q   <= ddata_w;
                cnt    <= CNT_INIT;
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == S_ACCESS && !wr_q)
                ddata_r <= load_val;
        end
    end

    assign word = mem[idx_q];

    always_comb begin
        shifted = word >> {lane_q, 3'b000};
        unique case (f3_q[1:0])
            2'b00:   load_val = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_val = word;
        endcase
    end

    always_comb begin
        unique case (f3_q[1:0])
            2'b00: begin
                be   = 4'b0001 << lane_q;
                wdat = {4{wd_q[7:0]}};
            end
            2'b01: begin
                be   = lane_q[1] ? 4'b1100 : 4'b0011;
                wdat = {2{wd_q[15:0]}};
            end
            default: begin
                be   = 4'b1111;
                wdat = wd_q;
            end
        endcase
    end

    // Array is not reset; async reset leaves ACCESS before any edge can write
    always_ff @(posedge CLK) begin
        if (state == S_ACCESS && wr_q) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx_q][8*i +: 8] <= wdat[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and randomized checks of dmem_ctrl
// against a byte-array reference model.
module tb_dmem_ctrl;
    localparam int WS     = 1;
    localparam int DEPTH  = 1024;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        stall;
    logic        mis;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  ref_mem [NBYTES];
    logic [31:0] exp_rd = 32'd0;
    logic [31:0] tmp;

    always #5 clk = ~clk;

    dmem_ctrl #(
        .ADDR_W(32),
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .MemRead(mem_rd),
        .MemWrite(mem_wr),
        .funct3(f3),
        .daddr(addr),
        .ddata_w(wdata),
        .ddata_r(rdata),
        .stall(stall),
        .misaligned(mis)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f);
        case (f[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit rejected(input logic [2:0] f,
                                    input logic [31:0] a);
`ifdef DMEM_MISALIGN_EN
        return (a % size_of(f)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int eff(input logic [2:0] f, input logic [31:0] a);
        int e;
        e = int'(a % NBYTES);
        return e - (e % size_of(f));
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f,
                                             input logic [31:0] a);
        logic [31:0] v;
        int e, n;
        v = 32'd0;
        e = eff(f, a);
        n = size_of(f);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[e+i];
        if (!f[2] && n < 4 && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [31:0] initw(input int k);
        return 32'h3C3C3C3C ^ (k * 32'h01010101);
    endfunction

    task automatic op(input bit wr, input bit rd, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d);
        int cyc;
        bit rej;
        int e;
        rej = rejected(f, a);
        mem_wr = wr;
        mem_rd = rd;
        f3     = f;
        addr   = a;
        wdata  = d;
        @(negedge clk);
        check("misaligned", {31'b0, mis}, {31'b0, rej});
        cyc = 0;
        while (stall && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
        if (!rej) begin
            if (wr) begin
                e = eff(f, a);
                for (int i = 0; i < size_of(f); i++)
                    ref_mem[e+i] = d[8*i +: 8];
            end else begin
                exp_rd = ref_load(f, a);
            end
        end
        check("stall_cycles", 32'(cyc), rej ? 32'd0 : 32'(WS + 2));
        check("ddata_r", rdata, exp_rd);
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
        mem_rd = 1'b0;
    endtask

    initial begin
        int kind;
        logic [2:0] rf;
        logic [31:0] ra;

        repeat (2) @(negedge clk);
        check("rst_ddata_r", rdata, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_misaligned", {31'b0, mis}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 20; k++) op(1, 0, 3'b010, 32'(4*k), initw(k));

        op(1, 0, 3'b010, 32'h10, 32'hDEADBEEF);
        op(0, 1, 3'b010, 32'h10, 32'd0);
        check("lw_10", rdata, 32'hDEADBEEF);

        op(1, 0, 3'b000, 32'h13, 32'h00000080);
        op(0, 1, 3'b000, 32'h13, 32'd0);
        check("lb_13", rdata, 32'hFFFFFF80);
        op(0, 1, 3'b100, 32'h13, 32'd0);
        check("lbu_13", rdata, 32'h00000080);
        op(0, 1, 3'b010, 32'h10, 32'd0);
        check("lw_10_sb", rdata, 32'h80ADBEEF);

        op(1, 0, 3'b001, 32'h22, 32'h00001234);
        op(0, 1, 3'b101, 32'h22, 32'd0);
        check("lhu_22", rdata, 32'h00001234);
        op(0, 1, 3'b010, 32'h20, 32'd0);
        tmp = initw(8);
        check("lw_20", rdata, {16'h1234, tmp[15:0]});

        op(0, 1, 3'b010, 32'h11, 32'd0);
`ifdef DMEM_MISALIGN_EN
        check("lw_11_held", rdata, {16'h1234, tmp[15:0]});
`else
        check("lw_11_low", rdata, 32'h80ADBEEF);
`endif

        op(1, 0, 3'b010, 32'h1000, 32'h5A5A5A5A);
        op(0, 1, 3'b010, 32'h0, 32'd0);
        check("wrap", rdata, 32'h5A5A5A5A);

        op(1, 1, 3'b010, 32'h4, 32'h11223344);
        check("both_no_load", rdata, 32'h5A5A5A5A);
        op(0, 1, 3'b010, 32'h4, 32'd0);
        check("both_write", rdata, 32'h11223344);

        mem_wr = 1'b1;
        f3     = 3'b010;
        addr   = 32'h40;
        wdata  = 32'hCAFEF00D;
        @(negedge clk);
        check("rst_req_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        check("rst_wait_stall", {31'b0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_stall", {31'b0, stall}, 32'd0);
        check("rst_mid_ddata", rdata, 32'd0);
        exp_rd = 32'd0;
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        op(0, 1, 3'b010, 32'h40, 32'd0);
        check("rst_no_write", rdata, initw(16));

        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 3);
            rf   = 3'($urandom_range(0, 7));
            ra   = 32'($urandom_range(0, 79)) +
                   (32'($urandom_range(0, 3)) << 12);
            op(kind == 1 || kind == 2, kind != 1, rf, ra, $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Parametrised data-memory controller between the core's data port and a synchronous word-organised RAM array. It supports RV32 byte, halfword and word loads and stores, with little-endian byte lanes and load sign/zero extension. A configurable number of wait states is applied to every access, and the core is held through a `stall` handshake until the access completes. It replaces the direct core-to-RAM connection in the top level.

## Interface
Parameters:
- `ADDR_W` = 32: width of `daddr`.
- `DEPTH_WORDS` = 1024: number of 32-bit words in the array. Must be a power of two.
- `WAIT_STATES` = 1: extra cycles inserted before each array access. Legal range 0..15.

Ports:
- `CLK` in 1: single clock; all state updates on the rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `MemRead` in 1: load request. Held stable by the core while `stall`=1.
- `MemWrite` in 1: store request. Held stable while `stall`=1.
- `funct3` in 3: access size and sign. 000 B, 001 H, 010 W, 100 BU, 101 HU. Codes 011, 110 and 111 are treated as W.
- `daddr` in ADDR_W: byte address.
- `ddata_w` in 32: store data, right-aligned.
- `ddata_r` out 32: load result, registered, extended to 32 bits.
- `stall` out 1: core must hold its pipeline and its request.
- `misaligned` out 1: one-cycle pulse on a rejected unaligned request.

## Operation
- Word index = `daddr[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so out-of-range addresses wrap modulo the array size.
- Lane = `daddr[1:0]`, little-endian.
- If `MemRead` and `MemWrite` are both high, the write wins and the read is dropped.
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - **IDLE**: on an aligned request, latch address, data, `funct3` and direction. Go to WAIT with `cnt` = WAIT_STATES-1, or go straight to ACCESS when WAIT_STATES = 0. `stall` = request & aligned (combinational).
  - **WAIT**: `stall`=1. `cnt` decrements each cycle; go to ACCESS on the cycle `cnt`=0.
  - **ACCESS**: `stall`=1.
    - Store: write only the byte-enabled lanes. SB uses lane addr[1:0]; SH uses lanes {addr[1],0}+0/1; SW uses all four.
    - Load: `ddata_r` ← selected bytes, sign-extended (B, H) or zero-extended (BU, HU).
    - Go to DONE.
  - **DONE**: `stall`=0. `ddata_r` is valid and the core advances on this edge. Any request present in DONE is ignored. Go to IDLE.
- `ddata_r` holds its value until the next load's ACCESS. Stores do not change it.
- Misaligned means H/HU with addr[0]=1, or W with addr[1:0]≠0. In IDLE this gives `misaligned`=1 for one cycle, `stall`=0, no array access, and the state stays IDLE.
- Reset mid-operation: state → IDLE and all outputs go to their reset values. A store not yet in ACCESS is never written. Array contents are not cleared by reset.

## Timing
- Reset values: `ddata_r`=0, `stall`=0, `misaligned`=0, state=IDLE, `cnt`=0.
- Request sampled at edge T0 (in IDLE): `stall` is high during cycles T0..T0+WAIT_STATES+1 and low in DONE, i.e. WAIT_STATES+2 stalled cycles including the request cycle.
- Load data is valid from the edge that enters DONE and stays stable afterwards.
- Store data is visible to a load issued in the cycle after DONE.
- Minimum back-to-back period is WAIT_STATES+3 cycles per access (the DONE cycle plus the re-entry to IDLE).

## Configuration
- `DMEM_MISALIGN_EN` defined: misaligned detection as described above. `misaligned` pulses and the access is suppressed.
- Not defined: `misaligned` is tied to 0. Unaligned H accesses use addr[0]=0 and unaligned W accesses use addr[1:0]=00 (the low bits are dropped), and the access proceeds normally.

## Test plan
- WAIT_STATES=1. SW 0xDEADBEEF to 0x10, then LW 0x10 → `stall` high 3 cycles per access; `ddata_r`=0xDEADBEEF in DONE.
- SB 0x80 to 0x13, then LB 0x13 and LBU 0x13 → 0xFFFFFF80 and 0x00000080. LW 0x10 → 0x80ADBEEF.
- SH 0x1234 to 0x22, then LHU 0x22 → 0x00001234. LW 0x20 → upper half 0x1234, lower half unchanged.
- With the macro defined: LW 0x11 → `misaligned`=1 for 1 cycle, `stall`=0, `ddata_r` unchanged. Without the macro: LW 0x11 returns the word at 0x10.
- DEPTH_WORDS=1024: SW 0x5A5A5A5A to 0x1000, then LW 0x0 → 0x5A5A5A5A (wrap). MemRead and MemWrite both high → the write is performed.
- WAIT_STATES=3. Assert `RESET` during WAIT of an SW to 0x40 → `stall`=0 immediately and `ddata_r`=0. A subsequent LW 0x40 returns the prior contents.
